// File: rtl/genbus_arb_pkg.sv
// genbus_arb_pkg: shared types and helpers for the genbus arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ACCESS, ABORT)
//   ARB_NM_MAX  : largest supported master count; sets the 3-bit bus ID width
//   lanes(dw)   : number of byte lanes for a data width
package genbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ABORT  = 2'd2
    } arb_state_e;

    localparam int ARB_NM_MAX = 8;

    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/genbus_rr_pick.sv
// genbus_rr_pick: combinational round-robin picker.
// The winner is the first requester at or after ptr. The search wraps from
// NM-1 back to 0.
// Ports:
//   req    in  NM  request vector
//   ptr    in  3   search start index (must be < NM)
//   onehot out NM  one-hot winner (all zero when no request)
//   idx    out 3   winner index (0 when no request)
//   any    out 1   at least one request present
module genbus_rr_pick
    import genbus_arb_pkg::*;
#(
    parameter int NM = 4
) (
    input  logic [NM-1:0] req,
    input  logic [2:0]    ptr,
    output logic [NM-1:0] onehot,
    output logic [2:0]    idx,
    output logic          any
);

    // Requests padded to the maximum width so a 3-bit index is always in range.
    logic [ARB_NM_MAX-1:0] req_x;
    logic [3:0]            sum;
    logic [2:0]            j;

    genvar gi;
    generate
        for (gi = 0; gi < ARB_NM_MAX; gi++) begin : g_pad
            if (gi < NM) begin : g_used
                assign req_x[gi] = req[gi];
            end else begin : g_zero
                assign req_x[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        idx = 3'd0;
        any = 1'b0;
        sum = 4'd0;
        j   = 3'd0;
        for (int k = 0; k < NM; k++) begin
            // ptr < NM, so one subtraction is enough to wrap the index.
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(NM)) begin
                sum = sum - 4'(NM);
            end
            j = sum[2:0];
            if (!any && req_x[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

    generate
        for (gi = 0; gi < NM; gi++) begin : g_oh
            assign onehot[gi] = any && (idx == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/genbus_arbiter.sv
// genbus_arbiter: round-robin arbiter that shares one genbus slave port
// between NM masters. The grant is registered. Each master gets its own wait
// state. An access whose slave holds s_ws for TMO cycles is aborted.
// Optional macro GENBUS_ARB_LOCK_EN adds m_lock[NM]. A master that completes
// an access with its lock bit set keeps the bus for its next access.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m_req/m_adr/m_we/m_re/m_wdata  per-master request fields (master i in slice i)
//   m_lock                     (GENBUS_ARB_LOCK_EN only) per-master lock
//   m_gnt, m_ws, m_err         per-master grant, wait state, timeout pulse
//   m_rdata                    broadcast read data
//   s_adr/s_we/s_re/s_wdata/s_id   slave-side request (zero when idle)
//   s_rdata, s_ws              slave read data and wait state
module genbus_arbiter
    import genbus_arb_pkg::*;
#(
    parameter int NM  = 4,
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NM-1:0]           m_req,
    input  logic [NM*AW-1:0]        m_adr,
    input  logic [NM*lanes(DW)-1:0] m_we,
    input  logic [NM*lanes(DW)-1:0] m_re,
    input  logic [NM*DW-1:0]        m_wdata,
`ifdef GENBUS_ARB_LOCK_EN
    input  logic [NM-1:0]           m_lock,
`endif
    output logic [NM-1:0]           m_gnt,
    output logic [NM-1:0]           m_ws,
    output logic [NM-1:0]           m_err,
    output logic [DW-1:0]           m_rdata,
    output logic [AW-1:0]           s_adr,
    output logic [lanes(DW)-1:0]    s_we,
    output logic [lanes(DW)-1:0]    s_re,
    output logic [DW-1:0]           s_wdata,
    output logic [2:0]              s_id,
    input  logic [DW-1:0]           s_rdata,
    input  logic                    s_ws
);

    localparam int         LW       = lanes(DW);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_ABORT  = ABORT;
    localparam logic [2:0] LAST     = 3'(NM - 1);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    // Per-master fields unpacked into arrays padded to ARB_NM_MAX entries,
    // so the 3-bit grant index can select from them directly.
    logic [AW-1:0]         adr_a [ARB_NM_MAX];
    logic [LW-1:0]         we_a  [ARB_NM_MAX];
    logic [LW-1:0]         re_a  [ARB_NM_MAX];
    logic [DW-1:0]         wd_a  [ARB_NM_MAX];
    logic [ARB_NM_MAX-1:0] req_x;
    logic [ARB_NM_MAX-1:0] lock_x;

    genvar gi;
    generate
        for (gi = 0; gi < ARB_NM_MAX; gi++) begin : g_unpack
            if (gi < NM) begin : g_used
                assign adr_a[gi] = m_adr[gi*AW +: AW];
                assign we_a[gi]  = m_we[gi*LW +: LW];
                assign re_a[gi]  = m_re[gi*LW +: LW];
                assign wd_a[gi]  = m_wdata[gi*DW +: DW];
                assign req_x[gi] = m_req[gi];
`ifdef GENBUS_ARB_LOCK_EN
                assign lock_x[gi] = m_lock[gi];
`else
                assign lock_x[gi] = 1'b0;
`endif
            end else begin : g_zero
                assign adr_a[gi]  = '0;
                assign we_a[gi]   = '0;
                assign re_a[gi]   = '0;
                assign wd_a[gi]   = '0;
                assign req_x[gi]  = 1'b0;
                assign lock_x[gi] = 1'b0;
            end
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [NM-1:0] gnt_oh_q, gnt_oh_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          in_access, in_abort, active, done, dropped, release_g;
    logic [2:0]    ptr_adv;
    logic [NM-1:0] pick_req, pick_oh;
    logic [2:0]    pick_ptr, pick_idx;
    logic          pick_any;

    assign in_access = (state_q == ST_ACCESS);
    assign in_abort  = (state_q == ST_ABORT);
    assign active    = in_access & req_x[gnt_q];
    assign done      = active & ~s_ws;
    assign dropped   = in_access & ~req_x[gnt_q];
    assign ptr_adv   = (gnt_q == LAST) ? 3'd0 : gnt_q + 3'd1;
    assign release_g = (in_access & ~s_ws) | in_abort;

    // In ACCESS the picker looks ahead for the next owner so there is no dead
    // cycle. The current owner is masked out because its request is still up
    // for the access that is just finishing.
    assign pick_req = in_access ? (m_req & ~gnt_oh_q) : m_req;
    assign pick_ptr = in_access ? ptr_adv : ptr_q;

    genbus_rr_pick #(.NM(NM)) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_oh_d = gnt_oh_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_ACCESS;
                    gnt_d    = pick_idx;
                    gnt_oh_d = pick_oh;
                    cnt_d    = 8'd0;
                end
            end
            ST_ACCESS: begin
                if (done && lock_x[gnt_q]) begin
                    // Locked owner keeps the bus and the pointer holds.
                    cnt_d = 8'd0;
                end else if (done || dropped) begin
                    ptr_d = ptr_adv;
                    if (pick_any) begin
                        gnt_d    = pick_idx;
                        gnt_oh_d = pick_oh;
                        cnt_d    = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    if (cnt_q >= TMO_LAST) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                ptr_d   = ptr_adv;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 3'd0;
            gnt_oh_q <= '0;
            ptr_q    <= 3'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_oh_q <= gnt_oh_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_gnt   = in_access ? gnt_oh_q : '0;
    assign m_err   = in_abort ? gnt_oh_q : '0;
    assign m_ws    = m_req & ~(gnt_oh_q & {NM{release_g}});
    assign m_rdata = s_rdata;

    // The slave side is driven only while the owner still requests. This keeps
    // it quiet in IDLE, in ABORT and in the cycle where the owner drops out.
    assign s_adr   = active ? adr_a[gnt_q] : '0;
    assign s_we    = active ? we_a[gnt_q]  : '0;
    assign s_re    = active ? re_a[gnt_q]  : '0;
    assign s_wdata = active ? wd_a[gnt_q]  : '0;
    assign s_id    = active ? gnt_q        : 3'd0;

endmodule

// File: tb/tb_genbus_arbiter.sv
module tb_genbus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  m_req;
    logic [63:0] m_adr;
    logic [7:0]  m_we;
    logic [7:0]  m_re;
    logic [63:0] m_wdata;
`ifdef GENBUS_ARB_LOCK_EN
    logic [3:0]  m_lock;
`endif
    logic [3:0]  m_gnt, m_ws, m_err;
    logic [15:0] m_rdata;
    logic [15:0] s_adr;
    logic [1:0]  s_we, s_re;
    logic [15:0] s_wdata;
    logic [2:0]  s_id;
    logic [15:0] s_rdata;
    logic        s_ws;

    genbus_arbiter #(.NM(4), .AW(16), .DW(16), .TMO(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_adr   (m_adr),
        .m_we    (m_we),
        .m_re    (m_re),
        .m_wdata (m_wdata),
`ifdef GENBUS_ARB_LOCK_EN
        .m_lock  (m_lock),
`endif
        .m_gnt   (m_gnt),
        .m_ws    (m_ws),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_adr   (s_adr),
        .s_we    (s_we),
        .s_re    (s_re),
        .s_wdata (s_wdata),
        .s_id    (s_id),
        .s_rdata (s_rdata),
        .s_ws    (s_ws)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ws;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic [3:0] mws;
        logic [3:0] err;
        logic [2:0] id;
        logic       act;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(input logic r, input logic [3:0] rq, input logic w,
                               input logic [3:0] lk, input logic [3:0] g,
                               input logic [3:0] mw, input logic [3:0] e,
                               input logic [2:0] id, input logic a);
        vec_t t;
        t.rst = r; t.req = rq; t.ws = w; t.lock = lk;
        t.gnt = g; t.mws = mw; t.err = e; t.id = id; t.act = a;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, compare 1 time unit later.
    task automatic apply(input vec_t t, input string tag, input logic [15:0] rd);
        logic [15:0] e_adr, e_wd;
        logic [1:0]  e_we, e_re;
        @(negedge clk);
        rst     = t.rst;
        m_req   = t.req;
        s_ws    = t.ws;
        s_rdata = rd;
`ifdef GENBUS_ARB_LOCK_EN
        m_lock  = t.lock;
`endif
        #1;
        e_adr = t.act ? (16'h1000 + 16'(t.id)) : 16'h0;
        e_wd  = t.act ? (16'hD000 + 16'(t.id)) : 16'h0;
        e_we  = (t.act && !t.id[0]) ? 2'b11 : 2'b00;
        e_re  = (t.act &&  t.id[0]) ? 2'b11 : 2'b00;
        chk({tag, ".m_gnt"},   32'(m_gnt),   32'(t.gnt));
        chk({tag, ".m_ws"},    32'(m_ws),    32'(t.mws));
        chk({tag, ".m_err"},   32'(m_err),   32'(t.err));
        chk({tag, ".s_id"},    32'(s_id),    32'(t.act ? t.id : 3'd0));
        chk({tag, ".s_adr"},   32'(s_adr),   32'(e_adr));
        chk({tag, ".s_we"},    32'(s_we),    32'(e_we));
        chk({tag, ".s_re"},    32'(s_re),    32'(e_re));
        chk({tag, ".s_wdata"}, 32'(s_wdata), 32'(e_wd));
        $display("%s: rst=%b req=%b ws=%b gnt=%b m_ws=%b err=%b s_id=%0d s_adr=%h",
                 tag, t.rst, t.req, t.ws, m_gnt, m_ws, m_err, s_id, s_adr);
    endtask

    initial begin
        rst = 1'b1; m_req = 4'b0; s_ws = 1'b0; s_rdata = 16'h0;
`ifdef GENBUS_ARB_LOCK_EN
        m_lock = 4'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            m_adr[i*16 +: 16]   = 16'h1000 + 16'(i);
            m_wdata[i*16 +: 16] = 16'hD000 + 16'(i);
            m_we[i*2 +: 2]      = (i % 2 == 0) ? 2'b11 : 2'b00;
            m_re[i*2 +: 2]      = (i % 2 == 0) ? 2'b00 : 2'b11;
        end
        repeat (2) @(posedge clk);

        // reset state: m_ws follows m_req, nothing granted
        tbl.push_back(v(1, 4'b0101, 0, 4'b0, 4'b0000, 4'b0101, 4'b0, 3'd0, 0));
        tbl.push_back(v(1, 4'b0000, 0, 4'b0, 4'b0000, 4'b0000, 4'b0, 3'd0, 0));
        // all four request: order 0,1,2,3,0,1,2,3 back to back
        tbl.push_back(v(0, 4'b1111, 0, 4'b0, 4'b0000, 4'b1111, 4'b0, 3'd0, 0));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(v(0, 4'b1111, 0, 4'b0, 4'b0001, 4'b1110, 4'b0, 3'd0, 1));
            tbl.push_back(v(0, 4'b1111, 0, 4'b0, 4'b0010, 4'b1101, 4'b0, 3'd1, 1));
            tbl.push_back(v(0, 4'b1111, 0, 4'b0, 4'b0100, 4'b1011, 4'b0, 3'd2, 1));
            tbl.push_back(v(0, 4'b1111, 0, 4'b0, 4'b1000, 4'b0111, 4'b0, 3'd3, 1));
        end
        // master 0 granted again, drops its request: access ends, no error
        tbl.push_back(v(0, 4'b0000, 0, 4'b0, 4'b0001, 4'b0000, 4'b0, 3'd0, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0, 4'b0000, 4'b0000, 4'b0, 3'd0, 0));
        // single master 0 (pointer 1, wraps to 0)
        tbl.push_back(v(0, 4'b0001, 0, 4'b0, 4'b0000, 4'b0001, 4'b0, 3'd0, 0));
        tbl.push_back(v(0, 4'b0001, 0, 4'b0, 4'b0001, 4'b0000, 4'b0, 3'd0, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0, 4'b0000, 4'b0000, 4'b0, 3'd0, 0));
        // pointer to 1 via master 0, then reset during a waited access of master 1
        tbl.push_back(v(0, 4'b0001, 0, 4'b0, 4'b0000, 4'b0001, 4'b0, 3'd0, 0));
        tbl.push_back(v(0, 4'b0001, 0, 4'b0, 4'b0001, 4'b0000, 4'b0, 3'd0, 1));
        tbl.push_back(v(0, 4'b0010, 0, 4'b0, 4'b0000, 4'b0010, 4'b0, 3'd0, 0));
        tbl.push_back(v(0, 4'b0010, 1, 4'b0, 4'b0010, 4'b0010, 4'b0, 3'd1, 1));
        tbl.push_back(v(1, 4'b0010, 1, 4'b0, 4'b0010, 4'b0010, 4'b0, 3'd1, 1));
        tbl.push_back(v(0, 4'b1001, 0, 4'b0, 4'b0000, 4'b1001, 4'b0, 3'd0, 0));
        // pointer back at 0: master 0 wins over master 3
        tbl.push_back(v(0, 4'b1001, 0, 4'b0, 4'b0001, 4'b1000, 4'b0, 3'd0, 1));
        tbl.push_back(v(0, 4'b1001, 0, 4'b0, 4'b1000, 4'b0001, 4'b0, 3'd3, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0, 4'b0001, 4'b0000, 4'b0, 3'd0, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0, 4'b0000, 4'b0000, 4'b0, 3'd0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i), 16'h0);
        end

        // master 2 read with three slave wait states
        apply(v(0, 4'b0100, 0, 4'b0, 4'b0000, 4'b0100, 4'b0, 3'd0, 0), "rd_req", 16'h0);
        for (int i = 0; i < 3; i++) begin
            apply(v(0, 4'b0100, 1, 4'b0, 4'b0100, 4'b0100, 4'b0, 3'd2, 1),
                  $sformatf("rd_ws%0d", i), 16'h0);
        end
        apply(v(0, 4'b0100, 0, 4'b0, 4'b0100, 4'b0000, 4'b0, 3'd2, 1), "rd_done", 16'hA55A);
        chk("rd_done.m_rdata", 32'(m_rdata), 32'h0000A55A);
        apply(v(0, 4'b0000, 0, 4'b0, 4'b0000, 4'b0000, 4'b0, 3'd0, 0), "rd_idle", 16'h0);

        // timeout: master 3 granted (pointer 3), s_ws stuck for 15 cycles
        apply(v(0, 4'b1010, 0, 4'b0, 4'b0000, 4'b1010, 4'b0, 3'd0, 0), "to_req", 16'h0);
        for (int i = 0; i < 15; i++) begin
            apply(v(0, 4'b1010, 1, 4'b0, 4'b1000, 4'b1010, 4'b0, 3'd3, 1),
                  $sformatf("to_ws%0d", i), 16'h0);
        end
        apply(v(0, 4'b1010, 1, 4'b0, 4'b0000, 4'b0010, 4'b1000, 3'd0, 0), "to_abort", 16'h0);
        apply(v(0, 4'b0010, 0, 4'b0, 4'b0000, 4'b0010, 4'b0, 3'd0, 0), "to_idle", 16'h0);
        apply(v(0, 4'b0010, 0, 4'b0, 4'b0010, 4'b0000, 4'b0, 3'd1, 1), "to_next", 16'h0);
        apply(v(0, 4'b0000, 0, 4'b0, 4'b0000, 4'b0000, 4'b0, 3'd0, 0), "to_end", 16'h0);

`ifdef GENBUS_ARB_LOCK_EN
        // master 3 locked for three accesses, then master 0
        apply(v(0, 4'b1001, 0, 4'b1000, 4'b0000, 4'b1001, 4'b0, 3'd0, 0), "lk_req", 16'h0);
        apply(v(0, 4'b1001, 0, 4'b1000, 4'b1000, 4'b0001, 4'b0, 3'd3, 1), "lk_a1", 16'h0);
        apply(v(0, 4'b1001, 0, 4'b1000, 4'b1000, 4'b0001, 4'b0, 3'd3, 1), "lk_a2", 16'h0);
        apply(v(0, 4'b1001, 0, 4'b0000, 4'b1000, 4'b0001, 4'b0, 3'd3, 1), "lk_a3", 16'h0);
        apply(v(0, 4'b1001, 0, 4'b0000, 4'b0001, 4'b1000, 4'b0, 3'd0, 1), "lk_m0", 16'h0);
        apply(v(0, 4'b0000, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0, 3'd0, 0), "lk_drop", 16'h0);
        apply(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0, 3'd0, 0), "lk_idle", 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
